// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32I sequencer.
// Steps FETCH/DECODE/EXECUTE/MEM/WB and latches a sticky trap.
module core_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       imem_rvalid_i,
  input  logic       dmem_rvalid_i,
  output logic       imem_req_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       alu_b_sel_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM = 2'd2;
  localparam logic [1:0] CAUSE_DMEM = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_cnt_inc;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause_nxt;

  logic w_is_op;
  logic w_is_opimm;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_legal;

  assign w_is_op     = (opcode_i == OPC_OP);
  assign w_is_opimm  = (opcode_i == OPC_OPIMM);
  assign w_is_load   = (opcode_i == OPC_LOAD);
  assign w_is_store  = (opcode_i == OPC_STORE);
  assign w_is_branch = (opcode_i == OPC_BRANCH);
  assign w_is_jal    = (opcode_i == OPC_JAL);
  assign w_is_jalr   = (opcode_i == OPC_JALR);
  assign w_is_lui    = (opcode_i == OPC_LUI);
  assign w_is_auipc  = (opcode_i == OPC_AUIPC);

  assign w_legal = w_is_op | w_is_opimm | w_is_load
                 | w_is_store | w_is_branch | w_is_jal
                 | w_is_jalr | w_is_lui | w_is_auipc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_cause <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_cnt_inc   = 1'b0;
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = PC_SEQ;
    alu_b_sel_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = WB_ALU;
    unique case (r_state)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_rvalid_i) begin
          ir_we_o     = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_IMEM;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        alu_b_sel_o = ~(w_is_op | w_is_branch);
        if (w_is_branch) begin
          pc_we_o     = 1'b1;
          pc_sel_o    = branch_taken_i ? PC_IMM : PC_SEQ;
          w_state_nxt = S_FETCH;
        end else if (w_is_load | w_is_store) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = w_is_store;
        if (dmem_rvalid_i) begin
          if (w_is_store) begin
            pc_we_o     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_DMEM;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we_o     = 1'b1;
        pc_we_o     = 1'b1;
        w_state_nxt = S_FETCH;
        unique case (1'b1)
          w_is_load:            wb_sel_o = WB_MEM;
          w_is_jal, w_is_jalr:  wb_sel_o = WB_PC4;
          w_is_lui:             wb_sel_o = WB_IMM;
          default:              wb_sel_o = WB_ALU;
        endcase
        unique case (1'b1)
          w_is_jal:  pc_sel_o = PC_IMM;
          w_is_jalr: pc_sel_o = PC_ALU;
          default:   pc_sel_o = PC_SEQ;
        endcase
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Wait counter restarts on every state change.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (w_cnt_inc) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  assign trap_o       = (r_state == S_TRAP);
  assign trap_cause_o = r_cause;

endmodule
